// File: rtl/forth_pkg.sv
// Shared definitions for the forth CPU subsystem.
//   - INSTR_WIDTH       : instruction word width (used by the CPU, the boot loader and the memory)
//   - SYNC_BYTE_DEFAULT : default frame start marker for the boot loader
//   - state_t           : boot loader state encoding
//   - in_frame()        : true in the states where a frame is being received
package forth_pkg;

    localparam int INSTR_WIDTH = 16;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA_LO,
        ST_DATA_HI,
        ST_CSUM,
        ST_RUN
    } state_t;

    // The inter-byte timeout is only armed while receiving a frame.
    function automatic logic in_frame(input state_t s);
        return (s != ST_IDLE) && (s != ST_RUN);
    endfunction

endpackage

// File: rtl/forth_imem.sv
// Instruction memory for the forth CPU: simple dual-port RAM, 2^addr_width words.
//   clk      : clock
//   we_i     : write strobe (from the boot loader)
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address (CPU iaddr)
//   rdata_o  : registered read data (CPU idata), valid one cycle after raddr_i
module forth_imem
    import forth_pkg::*;
#(
    parameter int addr_width = 10,
    parameter int data_width = INSTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [addr_width-1:0] waddr_i,
    input  logic [data_width-1:0] wdata_i,
    input  logic [addr_width-1:0] raddr_i,
    output logic [data_width-1:0] rdata_o
);

    logic [data_width-1:0] mem_q [2**addr_width];
    logic [data_width-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/forth_boot_loader.sv
// Boot loader for the forth CPU. Receives a framed program image from the UART
// receiver, writes it into instruction memory and releases the CPU from reset
// only after a complete frame with a valid checksum.
// Frame: sync_byte, LEN_LO, LEN_HI, LEN words (low byte first), CSUM; the 8-bit
// sum of all bytes after sync (including CSUM) must be zero.
//   clk, reset  : clock, synchronous active-high reset
//   rx_data     : received byte, qualified by rx_valid (1-cycle strobe)
//   reload      : 1-cycle request to put the CPU back in reset and await a new frame
//   imem_we/imem_waddr/imem_wdata : instruction memory write port
//   cpu_reset   : registered CPU reset, high while loading
//   load_done   : high while the CPU runs a verified image
//   load_error  : sticky error flag, cleared by the next sync byte
module forth_boot_loader
    import forth_pkg::*;
#(
    parameter int         iaddr_width    = 10,
    parameter int         instr_width    = INSTR_WIDTH,
    parameter logic [7:0] sync_byte      = SYNC_BYTE_DEFAULT,
    parameter int         timeout_cycles = 1000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic                   reload,
    output logic                   imem_we,
    output logic [iaddr_width-1:0] imem_waddr,
    output logic [instr_width-1:0] imem_wdata,
    output logic                   cpu_reset,
    output logic                   load_done,
    output logic                   load_error
);

    // One extra address bit so that a full-memory image (LEN = 2^iaddr_width) is legal.
    localparam int AW1  = iaddr_width + 1;
    localparam int TO_W = $clog2(timeout_cycles + 1);
    localparam logic [16:0] MAX_LEN = 17'(1) << iaddr_width;

    state_t                 state_q, state_d;
    logic [7:0]             sum_q, sum_d;
    logic [7:0]             len_lo_q, len_lo_d;
    logic [7:0]             data_lo_q, data_lo_d;
    logic [AW1-1:0]         addr_q, addr_d;
    logic [AW1-1:0]         rem_q, rem_d;
    logic [TO_W-1:0]        to_q, to_d;
    logic                   we_q, we_d;
    logic [iaddr_width-1:0] waddr_q, waddr_d;
    logic [instr_width-1:0] wdata_q, wdata_d;
    logic                   cpu_reset_q, cpu_reset_d;
    logic                   load_done_q, load_done_d;
    logic                   load_error_q, load_error_d;

    logic [7:0]  sum_plus;
    logic [15:0] len_full;
    logic        timeout;

    assign sum_plus = sum_q + rx_data;
    assign len_full = {rx_data, len_lo_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sum_q        <= '0;
            len_lo_q     <= '0;
            data_lo_q    <= '0;
            addr_q       <= '0;
            rem_q        <= '0;
            to_q         <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            len_lo_q     <= len_lo_d;
            data_lo_q    <= data_lo_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            to_q         <= to_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        len_lo_d     = len_lo_q;
        data_lo_d    = data_lo_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        to_d         = '0;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        cpu_reset_d  = cpu_reset_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;
        timeout      = 1'b0;

        // to_q counts idle cycles already elapsed; this cycle is idle cycle to_q+1.
        // A byte in the same cycle as the expiry wins.
        if (in_frame(state_q) && !rx_valid) begin
            if (to_q == TO_W'(timeout_cycles - 1)) begin
                timeout = 1'b1;
            end else begin
                to_d = to_q + 1'b1;
            end
        end

        if (reload) begin
            // Reload beats any simultaneous byte, which is dropped.
            state_d     = ST_IDLE;
            cpu_reset_d = 1'b1;
            load_done_d = 1'b0;
        end else if (timeout) begin
            state_d      = ST_IDLE;
            load_error_d = 1'b1;
            to_d         = '0;
        end else if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == sync_byte) begin
                        load_error_d = 1'b0;
                        sum_d        = '0;
                        addr_d       = '0;
                        state_d      = ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    len_lo_d = rx_data;
                    sum_d    = sum_plus;
                    state_d  = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    sum_d = sum_plus;
                    rem_d = AW1'(len_full);
                    if ({1'b0, len_full} > MAX_LEN) begin
                        load_error_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else if (len_full == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA_LO;
                    end
                end
                ST_DATA_LO: begin
                    data_lo_d = rx_data;
                    sum_d     = sum_plus;
                    state_d   = ST_DATA_HI;
                end
                ST_DATA_HI: begin
                    sum_d   = sum_plus;
                    we_d    = 1'b1;
                    waddr_d = addr_q[iaddr_width-1:0];
                    wdata_d = instr_width'({rx_data, data_lo_q});
                    addr_d  = addr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == AW1'(1)) ? ST_CSUM : ST_DATA_LO;
                end
                ST_CSUM: begin
                    sum_d = sum_plus;
                    if (sum_plus == 8'h00) begin
                        cpu_reset_d = 1'b0;
                        load_done_d = 1'b1;
                        state_d     = ST_RUN;
                    end else begin
                        load_error_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
                default: begin
                    // ST_RUN: the CPU owns the UART, bytes are ignored.
                end
            endcase
        end
    end

    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;

endmodule

// File: tb/tb_forth_boot_loader.sv
module tb_forth_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        reload;
    logic        imem_we;
    logic [9:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;
    logic [9:0]  raddr;
    logic [15:0] rdata;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    forth_boot_loader #(
        .iaddr_width   (10),
        .instr_width   (16),
        .sync_byte     (8'hA5),
        .timeout_cycles(50)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .reload    (reload),
        .imem_we   (imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .cpu_reset (cpu_reset),
        .load_done (load_done),
        .load_error(load_error)
    );

    forth_imem #(
        .addr_width(10),
        .data_width(16)
    ) imem (
        .clk    (clk),
        .we_i   (imem_we),
        .waddr_i(imem_waddr),
        .wdata_i(imem_wdata),
        .raddr_i(raddr),
        .rdata_o(rdata)
    );

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        rl;
        logic        we;
        logic [9:0]  wa;
        logic [15:0] wd;
        logic        cr;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [7:0] d, logic rl, logic we, logic [9:0] wa,
                                logic [15:0] wd, logic cr, logic dn, logic er);
        vec_t t;
        t.v = v; t.d = d; t.rl = rl; t.we = we; t.wa = wa; t.wd = wd;
        t.cr = cr; t.dn = dn; t.er = er;
        return t;
    endfunction

    // Loading-state byte with no write expected.
    function automatic vec_t byt(logic [7:0] d, logic er);
        return mk(1'b1, d, 1'b0, 1'b0, 10'd0, 16'd0, 1'b1, 1'b0, er);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge: drive inputs, let the next rising edge consume
    // them, and return at the following falling edge where outputs are sampled.
    task automatic cyc(input logic v, input logic [7:0] d, input logic rl);
        rx_valid = v;
        rx_data  = d;
        reload   = rl;
        @(negedge clk);
    endtask

    task automatic chk_status(input string name, input logic cr, input logic dn, input logic er);
        chk({name, "_cpu_reset"}, 32'(cpu_reset), 32'(cr));
        chk({name, "_load_done"}, 32'(load_done), 32'(dn));
        chk({name, "_load_error"}, 32'(load_error), 32'(er));
    endtask

    initial begin
        logic [7:0]  sum;
        logic [15:0] w;
        logic [7:0]  lo;
        logic [7:0]  hi;

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        raddr    = 10'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_waddr", 32'(imem_waddr), 32'd0);
        chk("rst_wdata", 32'(imem_wdata), 32'd0);
        chk_status("rst", 1'b1, 1'b0, 1'b0);
        $display("reset: cpu_reset=%0b load_done=%0b load_error=%0b", cpu_reset, load_done, load_error);
        reset = 1'b0;

        // Good frame. Sum of 02 00 34 12 78 56 is 8'h16, so the closing byte is 8'hEA.
        tbl.push_back(byt(8'hA5, 0));
        tbl.push_back(byt(8'h02, 0));
        tbl.push_back(byt(8'h00, 0));
        tbl.push_back(byt(8'h34, 0));
        tbl.push_back(mk(1, 8'h12, 0, 1, 10'd0, 16'h1234, 1, 0, 0));
        tbl.push_back(byt(8'h78, 0));
        tbl.push_back(mk(1, 8'h56, 0, 1, 10'd1, 16'h5678, 1, 0, 0));
        tbl.push_back(mk(1, 8'hEA, 0, 0, 10'd0, 16'd0, 0, 1, 0));
        tbl.push_back(mk(1, 8'hA5, 0, 0, 10'd0, 16'd0, 0, 1, 0));    // ignored in RUN
        tbl.push_back(mk(0, 8'h00, 1, 0, 10'd0, 16'd0, 1, 0, 0));    // reload
        // Bad checksum: both words still written, CPU stays in reset.
        tbl.push_back(byt(8'hA5, 0));
        tbl.push_back(byt(8'h02, 0));
        tbl.push_back(byt(8'h00, 0));
        tbl.push_back(byt(8'h34, 0));
        tbl.push_back(mk(1, 8'h12, 0, 1, 10'd0, 16'h1234, 1, 0, 0));
        tbl.push_back(byt(8'h78, 0));
        tbl.push_back(mk(1, 8'h56, 0, 1, 10'd1, 16'h5678, 1, 0, 0));
        tbl.push_back(byt(8'hEB, 1));
        tbl.push_back(byt(8'h00, 1));                                 // IDLE ignores non-sync
        // Zero-length good frame clears the error and runs.
        tbl.push_back(byt(8'hA5, 0));
        tbl.push_back(byt(8'h00, 0));
        tbl.push_back(byt(8'h00, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 10'd0, 16'd0, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 10'd0, 16'd0, 1, 0, 0));    // reload
        // Oversize: LEN = 1025.
        tbl.push_back(byt(8'hA5, 0));
        tbl.push_back(byt(8'h01, 0));
        tbl.push_back(byt(8'h04, 1));
        tbl.push_back(byt(8'h00, 1));
        // reload together with sync: sync dropped, so the zeros below start nothing.
        tbl.push_back(mk(1, 8'hA5, 1, 0, 10'd0, 16'd0, 1, 0, 1));
        tbl.push_back(byt(8'h00, 1));
        tbl.push_back(byt(8'h00, 1));
        tbl.push_back(byt(8'h00, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].rl);
            $display("vec %0d: v=%0b d=%02h rl=%0b -> we=%0b wa=%0h wd=%04h cr=%0b dn=%0b er=%0b",
                     i, tbl[i].v, tbl[i].d, tbl[i].rl, imem_we, imem_waddr, imem_wdata,
                     cpu_reset, load_done, load_error);
            chk($sformatf("v%0d_we", i), 32'(imem_we), 32'(tbl[i].we));
            if (tbl[i].we) begin
                chk($sformatf("v%0d_waddr", i), 32'(imem_waddr), 32'(tbl[i].wa));
                chk($sformatf("v%0d_wdata", i), 32'(imem_wdata), 32'(tbl[i].wd));
            end
            chk_status($sformatf("v%0d", i), tbl[i].cr, tbl[i].dn, tbl[i].er);
        end

        // Timeout: 50 idle cycles after a byte inside a frame.
        cyc(1, 8'hA5, 0);
        cyc(1, 8'h01, 0);
        repeat (49) cyc(0, 8'h00, 0);
        chk_status("to_49", 1'b1, 1'b0, 1'b0);
        cyc(0, 8'h00, 0);
        chk_status("to_50", 1'b1, 1'b0, 1'b1);
        $display("timeout: load_error=%0b after 50 idle cycles", load_error);

        // A byte landing on idle cycle 50 wins and is accepted.
        cyc(1, 8'hA5, 0);
        chk_status("to_sync", 1'b1, 1'b0, 1'b0);
        cyc(1, 8'h00, 0);
        repeat (49) cyc(0, 8'h00, 0);
        cyc(1, 8'h00, 0);
        chk_status("to_byte50", 1'b1, 1'b0, 1'b0);
        repeat (49) cyc(0, 8'h00, 0);
        cyc(1, 8'h00, 0);
        chk_status("to_run", 1'b0, 1'b1, 1'b0);
        $display("late byte: cpu_reset=%0b load_done=%0b", cpu_reset, load_done);
        cyc(0, 8'h00, 1);

        // Full-memory frame: LEN = 1024.
        cyc(1, 8'hA5, 0);
        cyc(1, 8'h00, 0);
        cyc(1, 8'h04, 0);
        sum = 8'h04;
        for (int i = 0; i < 1024; i++) begin
            w  = 16'(i) ^ 16'hC3A5;
            lo = w[7:0];
            hi = w[15:8];
            sum = sum + lo + hi;
            cyc(1, lo, 0);
            cyc(1, hi, 0);
            chk($sformatf("big_w%0d", i), {5'd0, imem_we, imem_waddr, imem_wdata},
                {5'd0, 1'b1, 10'(i), w});
        end
        $display("big frame: last write addr=%0h data=%04h", imem_waddr, imem_wdata);
        cyc(1, 8'(-sum), 0);
        chk_status("big_run", 1'b0, 1'b1, 1'b0);
        rx_valid = 1'b0;
        raddr = 10'h3FF;
        @(negedge clk);
        chk("mem_3ff", 32'(rdata), 32'(16'h03FF ^ 16'hC3A5));
        raddr = 10'h000;
        @(negedge clk);
        chk("mem_000", 32'(rdata), 32'(16'hC3A5));
        $display("readback: mem[0]=%04h", rdata);

        // Reset in the middle of the data phase.
        cyc(0, 8'h00, 1);
        cyc(1, 8'hA5, 0);
        cyc(1, 8'h02, 0);
        cyc(1, 8'h00, 0);
        cyc(1, 8'h34, 0);
        cyc(1, 8'h12, 0);
        cyc(1, 8'h78, 0);
        reset = 1'b1;
        cyc(0, 8'h00, 0);
        chk("mid_we", 32'(imem_we), 32'd0);
        chk("mid_waddr", 32'(imem_waddr), 32'd0);
        chk("mid_wdata", 32'(imem_wdata), 32'd0);
        chk_status("mid", 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        cyc(1, 8'h56, 0);
        cyc(1, 8'hEA, 0);
        chk("post_we", 32'(imem_we), 32'd0);
        chk_status("post", 1'b1, 1'b0, 1'b0);
        $display("mid-data reset: cpu_reset=%0b we=%0b", cpu_reset, imem_we);
        rx_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
